// File: rtl/axi_line_master_if.sv
// AXI4 bus between the cache-line master and the MIG s_axi_* slave port.
// Burst/lock/cache/prot are tied off at SoC level and are not carried here.
interface axi_line_master_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid, input  awready,
    output wdata, wstrb, wlast, wvalid,         input  wready,
    input  bid, bresp, bvalid,                  output bready,
    output arid, araddr, arlen, arsize, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid,    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid,         output wready,
    output bid, bresp, bvalid,                  input  bready,
    input  arid, araddr, arlen, arsize, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid,    input  rready
  );
endinterface

// File: rtl/axi_line_master.sv
// Cache-line AXI4 master: one whole-line request becomes one INCR burst, then the
// refill line or write status is returned. Single outstanding transaction.
module axi_line_master #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int BEATS      = 4,
  parameter int TXN_ID     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [BEATS*DATA_WIDTH-1:0]   req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_write,
  output logic [BEATS*DATA_WIDTH-1:0]   resp_rdata,
  output logic                          resp_err,
  axi_line_master_if.master             axi
);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int CNT_W  = BEAT_W + 1;
  localparam int OFF_W  = $clog2(BEATS * DATA_WIDTH / 8);
  localparam int SIZE   = $clog2(DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] NUM_BEATS = CNT_W'(BEATS);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, RESP
  } state_e;

  typedef logic [BEATS-1:0][DATA_WIDTH-1:0] line_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  line_t                 line_q, line_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  resp_valid_q, resp_valid_d;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    line_d       = line_q;
    beat_d       = beat_q;
    err_d        = err_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_valid_d = resp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d      = {req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
          write_d     = req_write;
          line_d      = req_wdata;
          err_d       = 1'b0;
          beat_d      = '0;
          req_ready_d = 1'b0;
          if (req_write) begin
            awvalid_d = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi.rvalid) begin
          // Beats beyond the line are still accepted to drain the burst, but not stored.
          if (beat_q < NUM_BEATS) line_d[beat_q[BEAT_W-1:0]] = axi.rdata;
          if (axi.rresp != 2'b00) err_d = 1'b1;
          if (axi.rlast) begin
            if (beat_q != LAST_BEAT) err_d = 1'b1;
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            if (beat_q >= LAST_BEAT) err_d = 1'b1;
            if (beat_q < NUM_BEATS) beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      WR_ADDR: begin
        if (axi.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (axi.wready) begin
          // The line shifts down so the next beat is always presented from slot 0.
          for (int i = 0; i < BEATS - 1; i++) line_d[i] = line_q[i + 1];
          if (beat_q == LAST_BEAT) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = WR_RESP;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          if (axi.bresp != 2'b00) err_d = 1'b1;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge _d values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // NOTE: the line buffer and address are not reset; they are reloaded on every accept before use.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    write_q <= write_d;
    line_q  <= line_d;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_write = write_q;
  assign resp_rdata = line_q;
  assign resp_err   = err_q;

  assign axi.awid    = ID_WIDTH'(TXN_ID);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'(BEATS - 1);
  assign axi.awsize  = 3'(SIZE);
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = line_q[0];
  assign axi.wstrb   = '1;
  assign axi.wlast   = (beat_q == LAST_BEAT);
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.arid    = ID_WIDTH'(TXN_ID);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = 3'(SIZE);
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // IDs are not checked with a single transaction in flight; offset bits are forced to zero.
  logic unused_bits;
  assign unused_bits = ^{axi.rid, axi.bid, req_addr[OFF_W-1:0]};
endmodule
